// File: rtl/fu_dispatch_if.sv
// fu_dispatch_if: issue-side and functional-unit-side handshake bundle of the operand dispatcher.
//   master : environment view (drives in_valid/in_sel/in_a/in_b and fu_ready)
//   slave  : dispatcher view (drives in_ready, fu_valid, fu_a, fu_b, busy)
interface fu_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       fu_valid;
    logic [3:0]       fu_ready;
    logic [WIDTH-1:0] fu_a;
    logic [WIDTH-1:0] fu_b;
    logic             busy;

    modport master (
        output in_valid, in_sel, in_a, in_b, fu_ready,
        input  in_ready, fu_valid, fu_a, fu_b, busy
    );

    modport slave (
        input  in_valid, in_sel, in_a, in_b, fu_ready,
        output in_ready, fu_valid, fu_a, fu_b, busy
    );
endinterface

// File: rtl/fu_dispatch.sv
// fu_dispatch: routes one issued operation to one of four functional units through a registered output stage.
//   clk            : clock, rising edge
//   rst_n          : asynchronous reset, active low
//   bus            : fu_dispatch_if.slave (in_valid/in_ready/in_sel/in_a/in_b, fu_valid/fu_ready/fu_a/fu_b, busy)
//   i_stats_clr    : zero all dispatch counters (DISPATCH_STATS_EN only)
//   o_dispatch_cnt : per-unit saturating delivery counters, unit k at [k*CNT_W +: CNT_W] (DISPATCH_STATS_EN only)
// Optional feature macro: DISPATCH_STATS_EN
module fu_dispatch #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef DISPATCH_STATS_EN
    input  logic               i_stats_clr,
    output logic [4*CNT_W-1:0] o_dispatch_cnt,
`endif
    fu_dispatch_if.slave       bus
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             w_full;
    logic             w_deliver;
    logic             w_in_ready;
    logic             w_accept;

    assign w_full     = r_state == S_FULL;
    assign w_deliver  = w_full & bus.fu_ready[r_sel];
    // A delivering slot can be refilled in the same cycle, giving one op per cycle.
    assign w_in_ready = !w_full | bus.fu_ready[r_sel];
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready = w_in_ready;
    assign bus.fu_valid = w_full ? 4'b0001 << r_sel : 4'b0000;
    assign bus.fu_a     = r_a;
    assign bus.fu_b     = r_b;
    assign bus.busy     = w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_sel   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_FULL;
                        r_sel   <= bus.in_sel;
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_sel <= bus.in_sel;
                        r_a   <= bus.in_a;
                        r_b   <= bus.in_b;
                    end else if (w_deliver) begin
                        r_state <= S_EMPTY;
                    end
                end
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt[k] <= '0;
            else if (i_stats_clr)
                r_cnt[k] <= '0;
            else if (w_deliver && r_sel == 2'(k) && r_cnt[k] != '1)
                r_cnt[k] <= r_cnt[k] + 1'b1;
        end
        assign o_dispatch_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
    end
`endif
endmodule
